alu_step_sequencer: RTL and testbench
=====================================

// Module: alu_step_sequencer
// PURPOSE
//  Control-step generator for register-register ALU instructions: Ra <= Rb op Rc.
//  Replaces hand-driven T-state strobes with an FSM emitting one-hot register gates
//  and Y/Z/HI/LO strobes to DataPath. Handles multi-cycle MUL/DIV: waits on alu_done
//  with a timeout, then writes the result to LO/HI.
// PARAMETERS
//  NUM_REGS    16       general registers; reg_out/reg_in width
//  IDX_W       4        register-index width; NUM_REGS <= 2**IDX_W
//  OP_W        5        ALU opcode width
//  OP_MUL      5'b01111 opcode for a wide (64-bit Z) multi-cycle op
//  OP_DIV      5'b10000 opcode for a wide (64-bit Z) multi-cycle op
//  MC_TIMEOUT  64       max WAIT cycles before abort; >= 1
// PORTS
//  clock     in   1         system clock; all state updates on posedge
//  clear     in   1         synchronous active-low reset
//  start     in   1         launch request; sampled in IDLE or the final step
//  opcode    in   OP_W      ALU operation; latched on accepted start
//  ra,rb,rc  in   IDX_W     dest / src A / src B indices; latched on accepted start
//  alu_done  in   1         multi-cycle ALU result valid; used for MUL/DIV only
//  busy      out  1         sequence in progress (any state except IDLE)
//  done      out  1         high for exactly the final step of a completed sequence
//  err       out  1         sticky fault flag
//  ops       out  OP_W      opcode to ALU; latched opcode in T1..final, 0 in IDLE
//  reg_out   out  NUM_REGS  one-hot register bus-drive gates
//  reg_in    out  NUM_REGS  one-hot register load strobes
//  ry_in, rz_in, rzlo_out, rzhi_out, lo_in, hi_in  out 1  datapath strobes
// BEHAVIOUR
//  - Reset (clear==0 at posedge): state=IDLE, all outputs 0, err=0. This takes
//    effect from any state; strobes are 0 from the next cycle and no write completes.
//  - All outputs are registered and decoded from the state register (Moore).
//  - States: IDLE, T1, T2, WAIT, T3, T4. wide = latched opcode is OP_MUL or OP_DIV.
//  - IDLE: start=1 -> latch opcode/ra/rb/rc, clear err, go T1. If any index >=
//    NUM_REGS -> set err, stay IDLE, no strobes.
//  - T1: reg_out[rb]=1, ry_in=1 -> T2.
//  - T2: reg_out[rc]=1, rz_in=1.
//      non-wide -> T3.
//      wide and alu_done=1 -> T3.
//      wide and alu_done=0 -> WAIT, clear wait counter.
//  - WAIT: rz_in=1, reg_out[rc]=1 held; counter increments each cycle.
//      alu_done=1 -> T3.
//      counter reaches MC_TIMEOUT -> set err, go IDLE, done stays 0.
//  - T3: rzlo_out=1.
//      non-wide: reg_in[ra]=1, done=1; this is the final step.
//      wide: lo_in=1, reg_in=0 -> T4.
//  - T4 (wide only): rzhi_out=1, hi_in=1, done=1; this is the final step.
//  - Final step: start=1 -> accept the new operands exactly as in IDLE (index check
//    included) and go to T1 with no bubble; otherwise go to IDLE.
//  - start in T1/T2/WAIT/non-final T3 is ignored. Operand inputs are don't-care
//    except at an accepted start.
//  - At most one bit set in reg_out and in reg_in; ra==rb==rc is legal.
//  - Latency, start seen at edge k: non-wide done in cycle k+3; wide with immediate
//    alu_done has done in k+4; each WAIT cycle adds 1.
// TESTING
//  1 ADD: opcode=5'b00011, ra=1, rb=2, rc=3.
//    -> k+1 reg_out=16'h0004 with ry_in.
//    -> k+2 reg_out=16'h0008 with rz_in and ops=3.
//    -> k+3 rzlo_out, reg_in=16'h0002, done. k+4 busy=0, ops=0.
//  2 MUL, rb=4, rc=5, alu_done raised 5 cycles after T2 -> 5 WAIT cycles holding
//    rz_in -> T3 with lo_in (no reg_in) -> T4 with hi_in and done; err=0.
//  3 MUL with MC_TIMEOUT=8, alu_done held 0 -> err=1 after 8 WAIT cycles, then IDLE.
//    done never asserts; no lo_in/hi_in/reg_in. Next valid start clears err.
//  4 Back-to-back: start held through the first ADD's T3 -> second T1 in the next
//    cycle. Two done pulses 3 cycles apart.
//  5 clear=0 during T2 of a MUL -> next cycle all strobes 0, busy=0.
//    A fresh ADD then completes normally.
//  6 NUM_REGS=12, start with ra=13 -> err=1, busy stays 0, no strobes.
//    Then ra=11 -> T3 asserts reg_in=12'h800.

Source files
------------

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: control-step FSM for Ra <= Rb op Rc with multi-cycle MUL/DIV wait and timeout
module alu_step_sequencer #(
  parameter int                NUM_REGS   = 16,
  parameter int                IDX_W      = 4,
  parameter int                OP_W       = 5,
  parameter logic [OP_W-1:0]   OP_MUL     = 5'b01111,
  parameter logic [OP_W-1:0]   OP_DIV     = 5'b10000,
  parameter int                MC_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OP_W-1:0]     opcode,
  input  logic [IDX_W-1:0]    ra,
  input  logic [IDX_W-1:0]    rb,
  input  logic [IDX_W-1:0]    rc,
  input  logic                alu_done,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [OP_W-1:0]     ops,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                ry_in,
  output logic                rz_in,
  output logic                rzlo_out,
  output logic                rzhi_out,
  output logic                lo_in,
  output logic                hi_in
);
  localparam int CNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [IDX_W:0] NR = (IDX_W + 1)'(NUM_REGS);
  typedef enum logic [2:0] {IDLE, T1, T2, WAIT, T3, T4} state_t;
  state_t state, state_n;
  logic [OP_W-1:0]  op_q;
  logic [IDX_W-1:0] ra_q, rb_q, rc_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             wide, final_step, launch, idx_ok, timeout;
  assign wide       = op_q == OP_MUL || op_q == OP_DIV;
  assign final_step = (state == T3 && !wide) || state == T4;
  assign launch     = start && (state == IDLE || final_step);
  assign idx_ok     = {1'b0, ra} < NR && {1'b0, rb} < NR && {1'b0, rc} < NR;
  assign timeout    = cnt == CNT_W'(MC_TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
      err_q <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == WAIT ? cnt + 1'b1 : '0;
      if (launch && idx_ok) begin
        op_q  <= opcode;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
        err_q <= 1'b0;
      end else if (launch || (state == WAIT && !alu_done && timeout)) begin
        err_q <= 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = launch && idx_ok ? T1 : IDLE;
      T1:      state_n = T2;
      T2:      state_n = !wide || alu_done ? T3 : WAIT;
      WAIT:    state_n = alu_done ? T3 : timeout ? IDLE : WAIT;
      T3:      state_n = wide ? T4 : launch && idx_ok ? T1 : IDLE;
      T4:      state_n = launch && idx_ok ? T1 : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy     = state != IDLE;
    done     = final_step;
    err      = err_q;
    ops      = state == IDLE ? '0 : op_q;
    reg_out  = state == T1 ? NUM_REGS'(1) << rb_q :
               (state == T2 || state == WAIT) ? NUM_REGS'(1) << rc_q : '0;
    reg_in   = state == T3 && !wide ? NUM_REGS'(1) << ra_q : '0;
    ry_in    = state == T1;
    rz_in    = state == T2 || state == WAIT;
    rzlo_out = state == T3;
    lo_in    = state == T3 && wide;
    rzhi_out = state == T4;
    hi_in    = state == T4;
  end
endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb_alu_step_sequencer: directed checks of the ALU step sequencer on a 16-register and a 12-register instance
module tb_alu_step_sequencer;
  logic        clock = 1'b0;
  logic        clear, start, alu_done;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy_a, done_a, err_a, ry_a, rz_a, rzlo_a, rzhi_a, lo_a, hi_a;
  logic [4:0]  ops_a;
  logic [15:0] rout_a, rin_a;
  logic        busy_b, done_b, err_b, ry_b, rz_b, rzlo_b, rzhi_b, lo_b, hi_b;
  logic [4:0]  ops_b;
  logic [11:0] rout_b, rin_b;
  logic [8:0]  flags_a, flags_b;
  int          checks = 0;
  int          errors = 0;
  always #5 clock = ~clock;
  // flag order: busy, done, err, ry_in, rz_in, rzlo_out, rzhi_out, lo_in, hi_in
  assign flags_a = {busy_a, done_a, err_a, ry_a, rz_a, rzlo_a, rzhi_a, lo_a, hi_a};
  assign flags_b = {busy_b, done_b, err_b, ry_b, rz_b, rzlo_b, rzhi_b, lo_b, hi_b};
  alu_step_sequencer #(.NUM_REGS(16), .MC_TIMEOUT(8)) dut_a (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
    .alu_done(alu_done), .busy(busy_a), .done(done_a), .err(err_a), .ops(ops_a),
    .reg_out(rout_a), .reg_in(rin_a), .ry_in(ry_a), .rz_in(rz_a), .rzlo_out(rzlo_a),
    .rzhi_out(rzhi_a), .lo_in(lo_a), .hi_in(hi_a));
  alu_step_sequencer #(.NUM_REGS(12)) dut_b (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
    .alu_done(alu_done), .busy(busy_b), .done(done_b), .err(err_b), .ops(ops_b),
    .reg_out(rout_b), .reg_in(rin_b), .ry_in(ry_b), .rz_in(rz_b), .rzlo_out(rzlo_b),
    .rzhi_out(rzhi_b), .lo_in(lo_b), .hi_in(hi_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic exp_a(input string tag, input logic [8:0] f, input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] op);
    chk({tag, ".flags"}, 32'(flags_a), 32'(f));
    chk({tag, ".reg_out"}, 32'(rout_a), 32'(ro));
    chk({tag, ".reg_in"}, 32'(rin_a), 32'(ri));
    chk({tag, ".ops"}, 32'(ops_a), 32'(op));
  endtask
  task automatic exp_b(input string tag, input logic [8:0] f, input logic [11:0] ro, input logic [11:0] ri);
    chk({tag, ".flags"}, 32'(flags_b), 32'(f));
    chk({tag, ".reg_out"}, 32'(rout_b), 32'(ro));
    chk({tag, ".reg_in"}, 32'(rin_b), 32'(ri));
  endtask
  task automatic launch(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    start = 1'b1; opcode = op; ra = d; rb = s1; rc = s2;
    tick();
  endtask
  initial begin
    clear = 1'b0; start = 1'b0; alu_done = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    tick(); tick();
    exp_a("reset", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    clear = 1'b1;
    // 1: ADD r1 <= r2 op r3
    launch(5'd3, 4'd1, 4'd2, 4'd3); start = 1'b0;
    exp_a("add.t1", 9'b100_100_000, 16'h0004, 16'h0, 5'd3);
    tick(); exp_a("add.t2", 9'b100_010_000, 16'h0008, 16'h0, 5'd3);
    tick(); exp_a("add.t3", 9'b110_001_000, 16'h0, 16'h0002, 5'd3);
    tick(); exp_a("add.idle", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    // 2: MUL with 5 WAIT cycles
    launch(5'd15, 4'd6, 4'd4, 4'd5); start = 1'b0;
    exp_a("mul.t1", 9'b100_100_000, 16'h0010, 16'h0, 5'd15);
    tick(); exp_a("mul.t2", 9'b100_010_000, 16'h0020, 16'h0, 5'd15);
    for (int i = 0; i < 5; i++) begin
      tick(); exp_a($sformatf("mul.wait%0d", i), 9'b100_010_000, 16'h0020, 16'h0, 5'd15);
    end
    alu_done = 1'b1;
    tick(); alu_done = 1'b0;
    exp_a("mul.t3", 9'b100_001_010, 16'h0, 16'h0, 5'd15);
    tick(); exp_a("mul.t4", 9'b110_000_101, 16'h0, 16'h0, 5'd15);
    tick(); exp_a("mul.idle", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    // 3: MUL timeout after 8 WAIT cycles
    launch(5'd15, 4'd2, 4'd1, 4'd3); start = 1'b0;
    tick(); exp_a("to.t2", 9'b100_010_000, 16'h0008, 16'h0, 5'd15);
    for (int i = 0; i < 8; i++) begin
      tick(); exp_a($sformatf("to.wait%0d", i), 9'b100_010_000, 16'h0008, 16'h0, 5'd15);
    end
    tick(); exp_a("to.abort", 9'b001_000_000, 16'h0, 16'h0, 5'd0);
    tick(); exp_a("to.sticky", 9'b001_000_000, 16'h0, 16'h0, 5'd0);
    launch(5'd3, 4'd1, 4'd2, 4'd3); start = 1'b0;
    exp_a("to.clr", 9'b100_100_000, 16'h0004, 16'h0, 5'd3);
    tick(); tick(); tick();
    exp_a("to.drain", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    // 4: back-to-back ADDs, operands changed mid-sequence are ignored until final step
    launch(5'd3, 4'd7, 4'd8, 4'd9);
    opcode = 5'd4; ra = 4'd10; rb = 4'd11; rc = 4'd12;
    exp_a("b2b.t1a", 9'b100_100_000, 16'h0100, 16'h0, 5'd3);
    tick(); exp_a("b2b.t2a", 9'b100_010_000, 16'h0200, 16'h0, 5'd3);
    tick(); exp_a("b2b.t3a", 9'b110_001_000, 16'h0, 16'h0080, 5'd3);
    tick(); start = 1'b0;
    exp_a("b2b.t1b", 9'b100_100_000, 16'h0800, 16'h0, 5'd4);
    tick(); exp_a("b2b.t2b", 9'b100_010_000, 16'h1000, 16'h0, 5'd4);
    tick(); exp_a("b2b.t3b", 9'b110_001_000, 16'h0, 16'h0400, 5'd4);
    tick(); exp_a("b2b.idle", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    // 5: reset during MUL T2
    launch(5'd15, 4'd1, 4'd2, 4'd3); start = 1'b0;
    tick(); exp_a("rst.t2", 9'b100_010_000, 16'h0008, 16'h0, 5'd15);
    clear = 1'b0;
    tick(); exp_a("rst.abort", 9'b000_000_000, 16'h0, 16'h0, 5'd0);
    clear = 1'b1;
    launch(5'd3, 4'd3, 4'd1, 4'd2); start = 1'b0;
    exp_a("rst.t1", 9'b100_100_000, 16'h0002, 16'h0, 5'd3);
    tick(); exp_a("rst.t2b", 9'b100_010_000, 16'h0004, 16'h0, 5'd3);
    tick(); exp_a("rst.t3", 9'b110_001_000, 16'h0, 16'h0008, 5'd3);
    tick();
    // 6: 12-register instance, index range check
    clear = 1'b0; tick(); clear = 1'b1;
    exp_b("nr12.reset", 9'b000_000_000, 12'h0, 12'h0);
    launch(5'd3, 4'd13, 4'd0, 4'd1); start = 1'b0;
    exp_b("nr12.bad", 9'b001_000_000, 12'h0, 12'h0);
    tick(); exp_b("nr12.stay", 9'b001_000_000, 12'h0, 12'h0);
    launch(5'd3, 4'd11, 4'd10, 4'd9); start = 1'b0;
    exp_b("nr12.t1", 9'b100_100_000, 12'h400, 12'h0);
    tick(); exp_b("nr12.t2", 9'b100_010_000, 12'h200, 12'h0);
    tick(); exp_b("nr12.t3", 9'b110_001_000, 12'h0, 12'h800);
    tick(); exp_b("nr12.idle", 9'b000_000_000, 12'h0, 12'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
